// File: rtl/la_acq_sequencer.sv
// Logic-analyzer acquisition sequencer: arm, pre-trigger fill, trigger match,
// post-trigger count, done; drives the circular write port of the sample RAM.
module la_acq_sequencer #(
  parameter int DW          = 48,
  parameter int AW          = 8,
  parameter int PRE_SAMPLES = 16
) (
  input  logic          PCI_CLK,
  input  logic          PCI_RST,
  input  logic          arm,
  input  logic          abort,
  input  logic [DW-1:0] probe,
  input  logic [DW-1:0] trig_mask,
  input  logic [DW-1:0] trig_value,
  input  logic          ext_trig,
  input  logic [AW-1:0] post_count,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] trig_addr,
  output logic [AW-1:0] start_addr,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] ONE_A     = AW'(1);
  localparam logic [AW-1:0] PRE_A     = AW'(PRE_SAMPLES);
  localparam logic [AW-1:0] FILL_LAST = AW'(PRE_SAMPLES - 1);
  localparam logic [AW-1:0] MAX_POST  = AW'(DEPTH - 1 - PRE_SAMPLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d;
  logic [AW-1:0] fill_cnt_q, fill_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic          wr_en_q, busy_q, done_q;
  logic          match;
  logic [AW-1:0] post_clamped;

  assign match        = (((probe ^ trig_value) & trig_mask) == '0) | ext_trig;
  // Clamp so the post-trigger writes never overrun the pre-trigger window.
  assign post_clamped = (post_count > MAX_POST) ? MAX_POST : post_count;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    if (wr_en_q) wr_addr_d = wr_addr_q + ONE_A;
    if (abort) begin
      state_d = S_IDLE;
    end else if (arm) begin
      state_d    = (PRE_SAMPLES == 0) ? S_ARMED : S_FILL;
      wr_addr_d  = '0;
      fill_cnt_d = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          fill_cnt_d = fill_cnt_q + ONE_A;
          if (fill_cnt_q == FILL_LAST) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (match) begin
            trig_addr_d = wr_addr_q;
            post_cnt_d  = post_clamped;
            state_d     = (post_clamped == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          post_cnt_d = post_cnt_q - ONE_A;
          if (post_cnt_q == ONE_A) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCI_CLK) begin
    if (PCI_RST) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      wr_en_q     <= (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
      busy_q      <= (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign wr_en      = wr_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_addr    = wr_addr_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = trig_addr_q - PRE_A;
  assign state      = state_q;

endmodule
